// File: rtl/bit_relation_pkg.sv
// Shared types and constants for the bitwise relation checkers.
//   rel_mode_e      : relation select encoding carried on in_mode
//   state_e         : packet accumulation FSM states
//   FIRST_FAIL_NONE : first-fail index reported when no beat failed (all-ones)
package bit_relation_pkg;

  typedef enum logic [1:0] {
    ModeSubset   = 2'd0,
    ModeEqual    = 2'd1,
    ModeDisjoint = 2'd2,
    ModeSuperset = 2'd3
  } rel_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  // Users truncate to their own counter width; all-ones stays all-ones.
  localparam int unsigned MAX_CNT_W = 64;
  localparam logic [MAX_CNT_W-1:0] FIRST_FAIL_NONE = '1;

endpackage

// File: rtl/bit_relation_eval.sv
// Combinational evaluation of one bitwise relation between two words.
//   a, b      : operand words
//   mode      : relation select (rel_mode_e encoding)
//   offending : bits that violate the relation
//   pass      : 1 when no bit violates the relation
module bit_relation_eval
  import bit_relation_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] offending,
  output logic             pass
);

  always_comb begin
    offending = '0;
    unique case (rel_mode_e'(mode))
      ModeSubset:   offending = a & ~b;  // bits of A missing from B
      ModeEqual:    offending = a ^ b;
      ModeDisjoint: offending = a & b;
      ModeSuperset: offending = b & ~a;  // bits of B missing from A
      default:      offending = '0;
    endcase
    pass = (offending == '0);
  end

endmodule

// File: rtl/bit_relation_checker.sv
// Streaming packet checker: evaluates a bitwise relation on every accepted
// beat and emits one registered summary per packet (delimited by in_last).
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : operand beat handshake (in_a, in_b, in_mode, in_last)
//   out_valid/ready : summary handshake
//   out_pass        : every beat of the packet passed
//   out_match_cnt   : passing beats (saturating)
//   out_beat_cnt    : total beats (saturating)
//   out_first_fail  : index of first failing beat, all-ones if none
//   out_fail_bits   : OR of offending vectors across the packet
module bit_relation_checker
  import bit_relation_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pass,
  output logic [CNT_W-1:0] out_match_cnt,
  output logic [CNT_W-1:0] out_beat_cnt,
  output logic [CNT_W-1:0] out_first_fail,
  output logic [WIDTH-1:0] out_fail_bits
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] FfNone = CNT_W'(FIRST_FAIL_NONE);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] beat_cnt_q, match_cnt_q, first_fail_q;
  logic             fail_seen_q;
  logic [WIDTH-1:0] fail_bits_q;

  logic             fire;
  logic [1:0]       eval_mode;
  logic [WIDTH-1:0] beat_off;
  logic             beat_pass;
  logic [CNT_W-1:0] beat_cnt_d, match_cnt_d, first_fail_d;
  logic             fail_seen_d;
  logic [WIDTH-1:0] fail_bits_d;

  assign in_ready = !(out_valid && !out_ready);
  assign fire     = in_valid && in_ready;

  // Mode is taken live on the first beat and from the latch afterwards.
  assign eval_mode = (state_q == StAccum) ? mode_q : in_mode;

  bit_relation_eval #(
    .WIDTH (WIDTH)
  ) u_eval (
    .a         (in_a),
    .b         (in_b),
    .mode      (eval_mode),
    .offending (beat_off),
    .pass      (beat_pass)
  );

  // Accumulators are all-clear outside StAccum, so they are the correct base
  // for both the first beat and later beats of a packet.
  always_comb begin
    beat_cnt_d   = (beat_cnt_q == CntMax) ? beat_cnt_q : beat_cnt_q + 1'b1;
    match_cnt_d  = match_cnt_q;
    if (beat_pass && (match_cnt_q != CntMax)) begin
      match_cnt_d = match_cnt_q + 1'b1;
    end
    // The pre-increment beat count is this beat's index; it saturates with it.
    first_fail_d = (!beat_pass && !fail_seen_q) ? beat_cnt_q : first_fail_q;
    fail_seen_d  = fail_seen_q | !beat_pass;
    fail_bits_d  = fail_bits_q | beat_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      mode_q         <= 2'd0;
      beat_cnt_q     <= '0;
      match_cnt_q    <= '0;
      first_fail_q   <= FfNone;
      fail_seen_q    <= 1'b0;
      fail_bits_q    <= '0;
      out_valid      <= 1'b0;
      out_pass       <= 1'b0;
      out_match_cnt  <= '0;
      out_beat_cnt   <= '0;
      out_first_fail <= FfNone;
      out_fail_bits  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (fire) begin
        if (in_last) begin
          // A new summary overrides the clear above when consume and load coincide.
          out_valid      <= 1'b1;
          out_pass       <= !fail_seen_d;
          out_match_cnt  <= match_cnt_d;
          out_beat_cnt   <= beat_cnt_d;
          out_first_fail <= first_fail_d;
          out_fail_bits  <= fail_bits_d;
          beat_cnt_q     <= '0;
          match_cnt_q    <= '0;
          first_fail_q   <= FfNone;
          fail_seen_q    <= 1'b0;
          fail_bits_q    <= '0;
          state_q        <= StHold;
        end else begin
          beat_cnt_q   <= beat_cnt_d;
          match_cnt_q  <= match_cnt_d;
          first_fail_q <= first_fail_d;
          fail_seen_q  <= fail_seen_d;
          fail_bits_q  <= fail_bits_d;
          if (state_q != StAccum) begin
            mode_q <= in_mode;
          end
          state_q <= StAccum;
        end
      end else if ((state_q == StHold) && out_ready) begin
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_bit_relation_checker.sv
// Self-checking bench: a 16-bit-counter and a 4-bit-counter instance share
// stimulus; a packet-level reference model predicts both summaries.
module tb_bit_relation_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_mode;

  logic        in_ready, out_valid, out_pass;
  logic [15:0] out_match_cnt, out_beat_cnt, out_first_fail;
  logic [31:0] out_fail_bits;

  logic        s_in_ready, s_out_valid, s_out_pass;
  logic [3:0]  s_match_cnt, s_beat_cnt, s_first_fail;
  logic [31:0] s_fail_bits;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_relation_checker #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_pass(out_pass), .out_match_cnt(out_match_cnt), .out_beat_cnt(out_beat_cnt),
    .out_first_fail(out_first_fail), .out_fail_bits(out_fail_bits)
  );

  bit_relation_checker #(.WIDTH(32), .CNT_W(4)) u_dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pass(s_out_pass), .out_match_cnt(s_match_cnt), .out_beat_cnt(s_beat_cnt),
    .out_first_fail(s_first_fail), .out_fail_bits(s_fail_bits)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
  } beat_t;

  typedef struct {
    logic        pass;
    logic [63:0] match;
    logic [63:0] beat;
    logic [63:0] ff;
    logic [31:0] fbits;
  } sum_t;

  beat_t pkt_q[$];
  sum_t  exp_l, exp_s;
  bit    have_sum = 0;
  bit    rand_ready = 0;

  // Bits that break the relation, straight from the set definitions.
  function automatic logic [31:0] offend(logic [31:0] a, logic [31:0] b, logic [1:0] m);
    case (m)
      2'd0:    return a & ~b;
      2'd1:    return a ^ b;
      2'd2:    return a & b;
      default: return b & ~a;
    endcase
  endfunction

  function automatic sum_t calc(int w);
    sum_t        s;
    longint      mx = (longint'(1) << w) - 1;
    longint      n = pkt_q.size();
    longint      np = 0;
    longint      first = -1;
    logic [31:0] fb = '0;
    logic [1:0]  m = pkt_q[0].mode;
    for (int i = 0; i < pkt_q.size(); i++) begin
      logic [31:0] off = offend(pkt_q[i].a, pkt_q[i].b, m);
      if (off == 0) np++;
      else if (first < 0) first = i;
      fb |= off;
    end
    s.pass  = (first < 0);
    s.beat  = (n > mx) ? mx : n;
    s.match = (np > mx) ? mx : np;
    s.ff    = (first < 0 || first > mx) ? mx : first;
    s.fbits = fb;
    return s;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    chk("out_valid", 64'(out_valid), 64'(have_sum));
    chk("s_out_valid", 64'(s_out_valid), 64'(have_sum));
    if (have_sum) begin
      chk("pass", 64'(out_pass), 64'(exp_l.pass));
      chk("match", 64'(out_match_cnt), exp_l.match);
      chk("beat", 64'(out_beat_cnt), exp_l.beat);
      chk("first_fail", 64'(out_first_fail), exp_l.ff);
      chk("fail_bits", 64'(out_fail_bits), 64'(exp_l.fbits));
      chk("s_pass", 64'(s_out_pass), 64'(exp_s.pass));
      chk("s_match", 64'(s_match_cnt), exp_s.match);
      chk("s_beat", 64'(s_beat_cnt), exp_s.beat);
      chk("s_first_fail", 64'(s_first_fail), exp_s.ff);
      chk("s_fail_bits", 64'(s_fail_bits), 64'(exp_s.fbits));
    end
  endtask

  // Called at a falling edge with inputs set; advances one cycle.
  task automatic tick();
    bit exp_ready, fire, cons;
    #1;
    exp_ready = !(have_sum && !out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("s_in_ready", 64'(s_in_ready), 64'(exp_ready));
    fire = in_valid && exp_ready;
    cons = have_sum && out_ready;
    if (cons) have_sum = 0;
    if (fire) begin
      pkt_q.push_back('{a: in_a, b: in_b, mode: in_mode});
      if (in_last) begin
        exp_l = calc(16);
        exp_s = calc(4);
        pkt_q.delete();
        have_sum = 1;
      end
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic send(logic [31:0] a, logic [31:0] b, logic [1:0] m, logic last);
    bit fired;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    in_last  = last;
    for (int t = 0; t < 50; t++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      fired = !(have_sum && !out_ready);
      tick();
      if (fired) return;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  task automatic rand_beat(logic last);
    logic [1:0]  m = 2'($urandom_range(0, 3));
    logic [31:0] b = $urandom();
    logic [31:0] r = $urandom();
    logic [31:0] a;
    case (m)
      2'd0:    a = b & r;
      2'd1:    a = b;
      2'd2:    a = ~b & r;
      default: a = b | r;
    endcase
    if ($urandom_range(0, 1) == 1) a ^= (32'd1 << $urandom_range(0, 31));
    send(a, b, m, last);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pass", 64'(out_pass), 64'd0);
    chk("rst_match", 64'(out_match_cnt), 64'd0);
    chk("rst_beat", 64'(out_beat_cnt), 64'd0);
    chk("rst_fbits", 64'(out_fail_bits), 64'd0);
    chk("rst_ff", 64'(out_first_fail), 64'hFFFF);
    chk("rst_s_ff", 64'(s_first_fail), 64'hF);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single SUBSET beat that passes.
    send(32'hA0A0_A0A0, 32'hF0F0_F0F0, 2'd0, 1'b1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pass", 64'(out_pass), 64'd1);
    chk("t1_match", 64'(out_match_cnt), 64'd1);
    chk("t1_beat", 64'(out_beat_cnt), 64'd1);
    chk("t1_ff", 64'(out_first_fail), 64'hFFFF);
    chk("t1_fbits", 64'(out_fail_bits), 64'd0);
    out_ready = 1'b1;
    idle(1);

    // EQUAL packet with one mismatching middle beat.
    out_ready = 1'b0;
    send(32'h5, 32'h5, 2'd1, 1'b0);
    send(32'h1, 32'h3, 2'd1, 1'b0);
    send(32'h7, 32'h7, 2'd3, 1'b1);
    chk("t2_pass", 64'(out_pass), 64'd0);
    chk("t2_match", 64'(out_match_cnt), 64'd2);
    chk("t2_beat", 64'(out_beat_cnt), 64'd3);
    chk("t2_ff", 64'(out_first_fail), 64'd1);
    chk("t2_fbits", 64'(out_fail_bits), 64'h2);
    out_ready = 1'b1;
    idle(1);

    // DISJOINT latched; second beat's SUBSET mode must be ignored.
    out_ready = 1'b0;
    send(32'hAAAA_AAAA, 32'h5555_5555, 2'd2, 1'b0);
    send(32'hAAAA_AAAA, 32'h5555_5555, 2'd0, 1'b1);
    chk("t3_pass", 64'(out_pass), 64'd1);
    chk("t3_match", 64'(out_match_cnt), 64'd2);
    out_ready = 1'b1;
    idle(1);

    // Back-pressure, then consume coinciding with a new single-beat packet.
    out_ready = 1'b0;
    send(32'h3, 32'h1, 2'd0, 1'b1);
    chk("t4_first_pass", 64'(out_pass), 64'd0);
    in_valid = 1'b1; in_a = 32'hF; in_b = 32'h1; in_mode = 2'd3; in_last = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_stall_ready", 64'(in_ready), 64'd0);
    chk("t4_stall_fbits", 64'(out_fail_bits), 64'h2);
    out_ready = 1'b1;
    tick();
    chk("t4_valid_kept", 64'(out_valid), 64'd1);
    chk("t4_new_pass", 64'(out_pass), 64'd1);
    chk("t4_new_fbits", 64'(out_fail_bits), 64'd0);
    idle(1);

    // 20 failing beats saturate the 4-bit counters.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(32'h1, 32'h0, 2'd0, logic'(i == 19));
    chk("t5_s_beat", 64'(s_beat_cnt), 64'd15);
    chk("t5_s_match", 64'(s_match_cnt), 64'd0);
    chk("t5_s_ff", 64'(s_first_fail), 64'd0);
    chk("t5_beat", 64'(out_beat_cnt), 64'd20);
    out_ready = 1'b1;
    idle(1);

    // Reset mid-packet, then reset while a summary is held.
    send(32'h1, 32'h1, 2'd1, 1'b0);
    send(32'h2, 32'h2, 2'd1, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd1);
    pkt_q.delete();
    have_sum = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    send(32'h9, 32'h9, 2'd1, 1'b1);
    chk("t6_beat", 64'(out_beat_cnt), 64'd1);
    chk("t6_pass", 64'(out_pass), 64'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_hold_rst_valid", 64'(out_valid), 64'd0);
    have_sum = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(1);

    // Back-to-back packets with out_ready held high.
    for (int p = 0; p < 8; p++) begin
      int len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) rand_beat(logic'(k == len - 1));
    end
    idle(2);

    // Randomised traffic with random stalls on both sides.
    rand_ready = 1;
    for (int p = 0; p < 80; p++) begin
      int len = (p % 13 == 0) ? $urandom_range(16, 22) : $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        rand_beat(logic'(k == len - 1));
      end
    end
    rand_ready = 0;
    out_ready = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_relation_checker.md
# bit_relation_checker

Streaming, parametrised successor to the single-word subset check. The block evaluates one of four bitwise relations between operand words A and B on every accepted beat, and accumulates the results across a packet delimited by `in_last`. At the end of each packet it emits one registered summary: overall pass flag, pass/beat counts, index of the first failing beat, and the OR of all offending bits. It sits between a valid/ready producer of operand pairs and a result consumer, such as a scoreboard or status CSR.

## Interface
Parameters:
- `WIDTH`, 32: operand width in bits.
- `CNT_W`, 16: width of the beat counters and the first-fail index.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat; a transfer occurs when `in_valid && in_ready`.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_mode`  in  2  relation select: 0 SUBSET, 1 EQUAL, 2 DISJOINT, 3 SUPERSET.
- `in_last`  in  1  marks the final beat of a packet.
- `out_valid`  out  1  summary valid.
- `out_ready`  in  1  consumer accepts the summary.
- `out_pass`  out  1  1 when every beat in the packet passed.
- `out_match_cnt`  out  CNT_W  number of passing beats.
- `out_beat_cnt`  out  CNT_W  total number of beats.
- `out_first_fail`  out  CNT_W  0-based index of the first failing beat; all-ones if no beat failed.
- `out_fail_bits`  out  WIDTH  OR of the offending vectors over all beats.

## Operation
- Offending vector per beat, by mode:
  - SUBSET: A & ~B.
  - EQUAL: A ^ B.
  - DISJOINT: A & B.
  - SUPERSET: B & ~A.
- A beat passes iff its offending vector is zero. SUBSET reproduces the legacy (A & B) == A check.
- Mode is latched on the first beat of a packet. `in_mode` on later beats of the same packet is ignored.
- FSM states:
  - IDLE: no beat accepted in the current packet. A non-last beat moves to ACCUM. A last beat loads the summary and moves to HOLD.
  - ACCUM: each accepted beat updates the accumulators. A last beat loads the summary and moves to HOLD.
  - HOLD: `out_valid` = 1. When `out_ready` = 1, go to IDLE, or stay in HOLD if a new single-beat packet is accepted in the same cycle.
- `in_ready` = !(out_valid && !out_ready). All input stalls while a summary is pending and not being consumed.
- Accumulators update on each transfer: beat counter +1; match counter +1 if the beat passed; fail_bits |= offending; first_fail captured on the first failing beat only.
- Counters saturate at 2^CNT_W−1 and never wrap. The first-fail index saturates with the beat counter.
- Summary load uses the accumulator state including the last beat. Accumulators clear in the same cycle, ready for the next packet.
- Summary outputs hold stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `out_valid` 0, `out_pass` 0.
  - `out_match_cnt`, `out_beat_cnt`, `out_fail_bits` 0.
  - `out_first_fail` all-ones.
  - FSM in IDLE, accumulators cleared.
- `in_ready` is 1 out of reset.
- Latency: `out_valid` rises on the cycle after the last-beat transfer.
- Throughput: one beat per cycle. Back-to-back packets incur no bubble when `out_ready` is held at 1.
- Simultaneous summary consume and new last beat: the new summary replaces the old one, and `out_valid` stays 1.
- Reset asserted mid-packet or in HOLD: partial accumulation is discarded immediately and asynchronously. No summary is emitted.
- `in_ready` is combinational from `out_valid`/`out_ready`. No other input-to-output combinational path exists.

## Structure
- Shared package `bit_relation_pkg` contains:
  - `rel_mode_e` enum with the four modes.
  - `FIRST_FAIL_NONE` constant (all-ones).
  - FSM state enum.
- Sub-module `bit_relation_eval`: purely combinational; inputs A, B, mode; outputs the offending vector and the pass bit. It is reused by other checkers.
- Top level holds the FSM, accumulators, and summary registers.

## Test plan
- SUBSET single beat, A=0xA0A0_A0A0, B=0xF0F0_F0F0 -> pass=1, match=1, beat=1, first_fail=0xFFFF, fail_bits=0.
- EQUAL 3-beat packet, beat 1 has A=0x1, B=0x3 and other beats are equal -> pass=0, match=2, beat=3, first_fail=1, fail_bits=0x2.
- DISJOINT packet with mode driven 2 on beat 0 and 0 on beat 1, A=0xAAAA_AAAA, B=0x5555_5555 on both -> mode latched, pass=1.
- Back-pressure: hold `out_ready`=0 for 5 cycles after a summary -> `in_ready`=0 and summary stable. Raise `out_ready` together with a single-beat SUPERSET packet, A=0xF, B=0x1 -> `out_valid` stays 1 and the new summary has pass=1.
- Saturation with CNT_W=4: 20-beat all-fail packet -> beat=15, match=0, first_fail=0.
- Assert `rst` in the middle of a 4-beat packet, then send a 1-beat packet -> beat=1, and no summary is emitted for the aborted packet.
